sync_flush_sequencer: RTL and testbench
=======================================

// Module: sync_flush_sequencer
// PURPOSE
//  Sequences synchronisation, cache-flush and halt instructions flagged by decode (synch_req/synch_op,
//  data_cache_flush, flushicache, halt). Stalls decode, drains outstanding memory/matmul work,
//  drives the D-cache then I-cache flush handshakes, and releases the instruction. Sits beside decode, ahead of issue.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  wait-state cycle limit before abort (used only with SYNC_TIMEOUT_EN)
// PORTS
//  clk               in   1  clock, all state on rising edge
//  rst_n             in   1  synchronous reset, active-low
//  op_valid          in   1  decode holds an instruction this cycle
//  synch_req         in   1  instruction is a fence
//  synch_op          in   2  0 full fence, 1 memory fence, 2 matmul fence, 3 treated as full fence
//  data_cache_flush  in   2  0 none, 1 clean, 2 invalidate, 3 clean+invalidate
//  flushicache       in   1  flush I-cache
//  halt              in   1  halt after drain
//  mem_idle          in   1  load/store path has no outstanding requests
//  matmul_idle       in   1  matrix multiplier idle
//  dflush_done       in   1  1-cycle pulse: D-cache flush complete
//  iflush_done       in   1  1-cycle pulse: I-cache flush complete
//  stall             out  1  hold decode
//  dflush_req        out  1  level request to D-cache
//  dflush_type       out  2  data_cache_flush value latched at accept
//  iflush_req        out  1  level request to I-cache
//  op_done           out  1  1-cycle pulse: instruction released
//  halted            out  1  core halted
//  timeout_err       out  1  sticky wait-timeout flag (SYNC_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): state IDLE; all outputs 0; latched fields cleared. Mid-operation reset aborts at once and drops dflush_req/iflush_req next edge.
//  - work = synch_req | (data_cache_flush!=0) | flushicache | halt. In IDLE, op_valid & !work: no stall, no op_done, no state change.
//  - IDLE, op_valid & work: latch fields; stall asserted combinationally this cycle; next state DRAIN.
//  - DRAIN: wait on drain condition: mem fence mem_idle; matmul fence matmul_idle; full fence/halt/any flush both.
//    Met -> DFLUSH if dflush_type!=0, else IFLUSH if flushicache, else HALTED if halt, else DONE.
//  - DFLUSH: dflush_req=1 until dflush_done seen; done and req share a cycle, req drops next cycle. Then IFLUSH/HALTED/DONE by the same priority.
//  - IFLUSH: iflush_req=1 until iflush_done. Then HALTED if halt, else DONE.
//  - DONE: stall=0, op_done=1 for one cycle. op_valid ignored (same instruction retiring). Next state IDLE.
//  - HALTED: stall=1, halted=1; exit only by reset.
//  - stall=1 in DRAIN, DFLUSH, IFLUSH, HALTED, and in IDLE on accept.
//  - Done pulses outside the matching wait state are ignored. Latched fields are stable while stalled; decode inputs are not sampled.
// CONFIGURATION
//  SYNC_TIMEOUT_EN defined:
//    - Counter clears on entry to DRAIN/DFLUSH/IFLUSH and increments each wait cycle.
//    - At count==TIMEOUT_CYCLES-1 with no completion: set timeout_err (sticky until reset), drop requests, go to DONE (instruction released).
//    - Completion in the same cycle as expiry wins; no error is set.
//  SYNC_TIMEOUT_EN undefined: no counter; waits are unbounded; timeout_err tied 0.
// STRUCTURE
//  - Package sync_ctrl_pkg:
//    - state_t enum {IDLE, DRAIN, DFLUSH, IFLUSH, DONE, HALTED}
//    - synch_op encodings SYNC_FULL/SYNC_MEM/SYNC_MATMUL
//    - flush encodings DF_NONE/DF_CLEAN/DF_INVAL/DF_CLEAN_INVAL
//  - Sub-module wait_timeout_counter (count width $clog2(TIMEOUT_CYCLES+1); inputs clear/enable; output expired). Instantiated only under SYNC_TIMEOUT_EN.
// TESTING
//  1 op_valid, all fields 0 -> stall stays 0, op_done never pulses, state IDLE.
//  2 synch_req, synch_op=1, mem_idle low 5 cycles -> stall 6 cycles incl. accept; op_done pulses on the cycle after mem_idle rises; dflush_req never set.
//  3 data_cache_flush=3, flushicache=1, idle inputs high; dflush_done after 4 cycles, iflush_done after 2 more
//    -> dflush_type=3; dflush_req then iflush_req, never overlapping; op_done pulses once.
//  4 halt=1 with matmul_idle low 3 cycles -> halted=1 and stall=1 persist 100 cycles; rst_n low 1 cycle clears both.
//  5 rst_n low while in DFLUSH -> next edge dflush_req=0, stall=0, state IDLE; a late dflush_done is ignored.
//  6 (SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=8) mem_idle held low -> after 8 DRAIN cycles timeout_err=1 and op_done pulses. Repeat with mem_idle rising on cycle 8 -> timeout_err stays 0.

Source files
------------

// File: rtl/sync_ctrl_pkg.sv
// Shared encodings for the sync/flush sequencer: FSM states, fence kinds,
// D-cache flush kinds and the "what comes after the D-cache flush" helper.
package sync_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DFLUSH,
        IFLUSH,
        DONE,
        HALTED
    } state_t;

    // synch_op encodings; value 3 is handled as a full fence
    localparam logic [1:0] SYNC_FULL   = 2'd0;
    localparam logic [1:0] SYNC_MEM    = 2'd1;
    localparam logic [1:0] SYNC_MATMUL = 2'd2;

    // data_cache_flush encodings
    localparam logic [1:0] DF_NONE        = 2'd0;
    localparam logic [1:0] DF_CLEAN       = 2'd1;
    localparam logic [1:0] DF_INVAL       = 2'd2;
    localparam logic [1:0] DF_CLEAN_INVAL = 2'd3;

    // Remaining work once the D-cache stage is finished or skipped
    function automatic state_t tail_state(input logic iflush, input logic halt);
        if (iflush)
            return IFLUSH;
        else if (halt)
            return HALTED;
        else
            return DONE;
    endfunction

endpackage

// File: rtl/wait_timeout_counter.sv
// Wait-state cycle counter: clears on entry to a wait state, counts each
// wait cycle and flags the last permitted cycle.
module wait_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Count wait cycles; a state transition restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (enable)
            count_q <= count_q + CW'(1);
    end

    assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sync_flush_sequencer.sv
// Sequences fence / cache-flush / halt instructions from decode: stalls
// decode, drains memory and matmul work, runs the D-cache then I-cache flush
// handshakes and releases (or halts on) the instruction.
// Optional feature: define SYNC_TIMEOUT_EN to bound every wait state by
// TIMEOUT_CYCLES and report expiry on timeout_err.
module sync_flush_sequencer
    import sync_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic       synch_req,
    input  logic [1:0] synch_op,
    input  logic [1:0] data_cache_flush,
    input  logic       flushicache,
    input  logic       halt,
    input  logic       mem_idle,
    input  logic       matmul_idle,
    input  logic       dflush_done,
    input  logic       iflush_done,
    output logic       stall,
    output logic       dflush_req,
    output logic [1:0] dflush_type,
    output logic       iflush_req,
    output logic       op_done,
    output logic       halted,
    output logic       timeout_err
);

    state_t     state_q, state_d;
    logic [1:0] op_q;
    logic [1:0] dft_q;
    logic       iflush_q;
    logic       halt_q;
    logic       work;
    logic       accept;
    logic       drain_met;

    assign work        = synch_req | (data_cache_flush != DF_NONE) | flushicache | halt;
    assign accept      = (state_q == IDLE) && op_valid && work;
    assign dflush_type = dft_q;

    // Drain condition: flushes and halt need everything quiet; plain fences
    // wait only on the unit they order
    always_comb begin
        drain_met = mem_idle & matmul_idle;
        if (!halt_q && (dft_q == DF_NONE) && !iflush_q) begin
            case (op_q)
                SYNC_MEM:    drain_met = mem_idle;
                SYNC_MATMUL: drain_met = matmul_idle;
                default:     drain_met = mem_idle & matmul_idle;
            endcase
        end
    end

`ifdef SYNC_TIMEOUT_EN
    logic waiting;
    logic wait_done;
    logic expired;
    logic timeout_hit;
    logic timeout_err_q;

    assign waiting     = (state_q == DRAIN) || (state_q == DFLUSH) || (state_q == IFLUSH);
    assign wait_done   = ((state_q == DRAIN)  && drain_met)   ||
                         ((state_q == DFLUSH) && dflush_done) ||
                         ((state_q == IFLUSH) && iflush_done);
    // Completion on the expiry cycle takes precedence over the timeout
    assign timeout_hit = waiting && !wait_done && expired;
    assign timeout_err = timeout_err_q;

    wait_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timeout_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != state_d),
        .enable  (waiting),
        .expired (expired)
    );

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            timeout_err_q <= 1'b0;
        else if (timeout_hit)
            timeout_err_q <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Capture instruction fields at accept; held stable while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= SYNC_FULL;
            dft_q    <= DF_NONE;
            iflush_q <= 1'b0;
            halt_q   <= 1'b0;
        end else if (accept) begin
            op_q     <= synch_op;
            dft_q    <= data_cache_flush;
            iflush_q <= flushicache;
            halt_q   <= halt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        dflush_req = 1'b0;
        iflush_req = 1'b0;
        op_done    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (drain_met)
                    state_d = (dft_q != DF_NONE) ? DFLUSH : tail_state(iflush_q, halt_q);
            end
            DFLUSH: begin
                stall      = 1'b1;
                dflush_req = 1'b1;
                if (dflush_done)
                    state_d = tail_state(iflush_q, halt_q);
            end
            IFLUSH: begin
                stall      = 1'b1;
                iflush_req = 1'b1;
                if (iflush_done)
                    state_d = halt_q ? HALTED : DONE;
            end
            DONE: begin
                op_done = 1'b1;
                state_d = IDLE;
            end
            HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef SYNC_TIMEOUT_EN
        if (timeout_hit)
            state_d = DONE;
`endif
    end

endmodule

// File: tb/tb_sync_flush_sequencer.sv
// Directed bench for sync_flush_sequencer: fence, flush, halt and reset
// scenarios with per-cycle expected outputs.
module tb_sync_flush_sequencer;
    import sync_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       synch_req;
    logic [1:0] synch_op;
    logic [1:0] data_cache_flush;
    logic       flushicache;
    logic       halt;
    logic       mem_idle;
    logic       matmul_idle;
    logic       dflush_done;
    logic       iflush_done;
    logic       stall;
    logic       dflush_req;
    logic [1:0] dflush_type;
    logic       iflush_req;
    logic       op_done;
    logic       halted;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    sync_flush_sequencer #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_valid         (op_valid),
        .synch_req        (synch_req),
        .synch_op         (synch_op),
        .data_cache_flush (data_cache_flush),
        .flushicache      (flushicache),
        .halt             (halt),
        .mem_idle         (mem_idle),
        .matmul_idle      (matmul_idle),
        .dflush_done      (dflush_done),
        .iflush_done      (iflush_done),
        .stall            (stall),
        .dflush_req       (dflush_req),
        .dflush_type      (dflush_type),
        .iflush_req       (iflush_req),
        .op_done          (op_done),
        .halted           (halted),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        op_valid         = 1'b0;
        synch_req        = 1'b0;
        synch_op         = 2'd0;
        data_cache_flush = 2'd0;
        flushicache      = 1'b0;
        halt             = 1'b0;
        mem_idle         = 1'b1;
        matmul_idle      = 1'b1;
        dflush_done      = 1'b0;
        iflush_done      = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        #4;
        checks++;
        if ({stall, dflush_req, dflush_type, iflush_req, op_done, halted, timeout_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {stall, dflush_req, dflush_type, iflush_req, op_done, halted, timeout_err});
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_no_work();
        clear_inputs();
        op_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #4;
            checks++;
            if (stall !== 1'b0 || op_done !== 1'b0) begin
                errors++;
                $display("FAIL no_work c%0d: got stall=%b op_done=%b want 0 0", c, stall, op_done);
            end
            checks++;
            if (dut.state_q !== IDLE) begin
                errors++;
                $display("FAIL no_work_state c%0d: got %0d want %0d", c, dut.state_q, IDLE);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mem_fence();
        clear_inputs();
        matmul_idle = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            op_valid  = (c <= 6);
            synch_req = (c <= 6);
            synch_op  = (c <= 6) ? 2'd1 : 2'd0;
            mem_idle  = (c >= 5);
            #4;
            checks++;
            if (stall !== (c <= 5)) begin
                errors++;
                $display("FAIL mem_fence_stall c%0d: got %b want %b", c, stall, (c <= 5));
            end
            checks++;
            if (op_done !== (c == 6)) begin
                errors++;
                $display("FAIL mem_fence_done c%0d: got %b want %b", c, op_done, (c == 6));
            end
            checks++;
            if (dflush_req !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL mem_fence_dreq c%0d: got dreq=%b terr=%b want 0 0", c, dflush_req, timeout_err);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_flush_sequence();
        int done_cnt = 0;
        clear_inputs();
        for (int c = 0; c <= 9; c++) begin
            op_valid         = (c <= 8);
            flushicache      = (c <= 8);
            data_cache_flush = (c > 8) ? 2'd0 : ((c >= 3) ? 2'd1 : 2'd3);
            dflush_done      = (c == 1 || c == 5);
            iflush_done      = (c == 3 || c == 7);
            #4;
            if (op_done === 1'b1) done_cnt++;
            checks++;
            if (stall !== (c <= 7)) begin
                errors++;
                $display("FAIL flush_stall c%0d: got %b want %b", c, stall, (c <= 7));
            end
            checks++;
            if (dflush_req !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL flush_dreq c%0d: got %b want %b", c, dflush_req, (c >= 2 && c <= 5));
            end
            checks++;
            if (iflush_req !== (c >= 6 && c <= 7)) begin
                errors++;
                $display("FAIL flush_ireq c%0d: got %b want %b", c, iflush_req, (c >= 6 && c <= 7));
            end
            checks++;
            if (op_done !== (c == 8)) begin
                errors++;
                $display("FAIL flush_done c%0d: got %b want %b", c, op_done, (c == 8));
            end
            if (c >= 1) begin
                checks++;
                if (dflush_type !== 2'd3) begin
                    errors++;
                    $display("FAIL flush_type c%0d: got %0d want 3", c, dflush_type);
                end
            end
            next_cycle();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL flush_done_count: got %0d want 1", done_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        clear_inputs();
        for (int c = 0; c <= 103; c++) begin
            op_valid    = 1'b1;
            halt        = 1'b1;
            matmul_idle = (c >= 3);
            #4;
            checks++;
            if (stall !== 1'b1 || halted !== (c >= 4)) begin
                errors++;
                $display("FAIL halt c%0d: got stall=%b halted=%b want 1 %b", c, stall, halted, (c >= 4));
            end
            next_cycle();
        end
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #4;
        checks++;
        if (halted !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: got stall=%b halted=%b want 0 0", stall, halted);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_flush();
        clear_inputs();
        op_valid         = 1'b1;
        data_cache_flush = 2'd2;
        next_cycle();
        next_cycle();
        #4;
        checks++;
        if (dflush_req !== 1'b1 || dflush_type !== 2'd2) begin
            errors++;
            $display("FAIL midrst_pre: got dreq=%b type=%0d want 1 2", dflush_req, dflush_type);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #4;
        checks++;
        if (dflush_req !== 1'b0 || stall !== 1'b0 || dflush_type !== 2'd0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL midrst_post: got dreq=%b stall=%b type=%0d state=%0d want 0 0 0 %0d",
                     dflush_req, stall, dflush_type, dut.state_q, IDLE);
        end
        next_cycle();
        dflush_done = 1'b1;
        next_cycle();
        dflush_done = 1'b0;
        #4;
        checks++;
        if (dflush_req !== 1'b0 || op_done !== 1'b0 || stall !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL midrst_late_done: got dreq=%b done=%b stall=%b state=%0d want 0 0 0 %0d",
                     dflush_req, op_done, stall, dut.state_q, IDLE);
        end
        next_cycle();
    endtask

`ifdef SYNC_TIMEOUT_EN
    task automatic test_timeout();
        for (int rep = 0; rep < 2; rep++) begin
            clear_inputs();
            for (int c = 0; c <= 10; c++) begin
                op_valid  = (c <= 8);
                synch_req = (c <= 8);
                synch_op  = 2'd1;
                mem_idle  = (rep == 1) && (c >= 8);
                #4;
                checks++;
                if (stall !== (c <= 8) || op_done !== (c == 9)) begin
                    errors++;
                    $display("FAIL timeout_flow r%0d c%0d: got stall=%b done=%b want %b %b",
                             rep, c, stall, op_done, (c <= 8), (c == 9));
                end
                checks++;
                if (timeout_err !== ((rep == 0) && (c >= 9))) begin
                    errors++;
                    $display("FAIL timeout_err r%0d c%0d: got %b want %b",
                             rep, c, timeout_err, ((rep == 0) && (c >= 9)));
                end
                next_cycle();
            end
            clear_inputs();
            pulse_reset();
            #4;
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_clear r%0d: got %b want 0", rep, timeout_err);
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_no_work();
        test_mem_fence();
        test_flush_sequence();
        test_halt();
        test_reset_mid_flush();
`ifdef SYNC_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
